// File: rtl/fft_lane_serializer_if.sv
// Beat-in / serial-out bus for the FFT lane serializer.
// The master side drives beats and ready; the slave side is the serializer.
interface fft_lane_serializer_if #(
    parameter int unsigned DATA_WIDTH = 13,
    parameter int unsigned LANES      = 16,
    parameter int unsigned DEPTH      = 4
);
    localparam int unsigned IDX_W = $clog2(2 * LANES);
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    logic                             din_valid;
    logic [LANES-1:0][DATA_WIDTH-1:0] din_add_r;
    logic [LANES-1:0][DATA_WIDTH-1:0] din_add_i;
    logic [LANES-1:0][DATA_WIDTH-1:0] din_sub_r;
    logic [LANES-1:0][DATA_WIDTH-1:0] din_sub_i;

    logic                  dout_valid;
    logic                  dout_ready;
    logic [DATA_WIDTH-1:0] dout_r;
    logic [DATA_WIDTH-1:0] dout_i;
    logic [IDX_W-1:0]      dout_idx;
    logic                  dout_last;
    logic                  overflow;
    logic [LVL_W-1:0]      level;

    modport master (
        output din_valid, din_add_r, din_add_i, din_sub_r, din_sub_i, dout_ready,
        input  dout_valid, dout_r, dout_i, dout_idx, dout_last, overflow, level
    );

    modport slave (
        input  din_valid, din_add_r, din_add_i, din_sub_r, din_sub_i, dout_ready,
        output dout_valid, dout_r, dout_i, dout_idx, dout_last, overflow, level
    );
endinterface

// File: rtl/fft_lane_serializer.sv
// Captures parallel add/sub FFT lane beats into a beat FIFO and drains them
// as a serial complex stream; beats arriving while full are dropped and flagged.
module fft_lane_serializer #(
    parameter int unsigned DATA_WIDTH = 13,
    parameter int unsigned LANES      = 16,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    fft_lane_serializer_if.slave   bus
);
    localparam int unsigned NSAMP = 2 * LANES;
    localparam int unsigned SEL_W = $clog2(NSAMP);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] mem_r_q [DEPTH][NSAMP];
    logic [DATA_WIDTH-1:0] mem_i_q [DEPTH][NSAMP];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic [SEL_W-1:0] sel_q,    sel_d;
    logic             overflow_q, overflow_d;

    logic dout_valid_c;
    logic xfer_c;
    logic pop_last_c;
    logic accept_c;

    // Handshake decode; a full FIFO can still accept when its head beat retires this cycle.
    always_comb begin
        dout_valid_c = (count_q != '0);
        xfer_c       = dout_valid_c & bus.dout_ready;
        pop_last_c   = xfer_c & (sel_q == SEL_W'(NSAMP - 1));
        accept_c     = bus.din_valid & ((count_q < CNT_W'(DEPTH)) | pop_last_c);
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        sel_d      = sel_q;
        overflow_d = overflow_q;

        if (accept_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else if (bus.din_valid) begin
            overflow_d = 1'b1;
        end

        if (pop_last_c) begin
            sel_d    = '0;
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else if (xfer_c) begin
            sel_d = sel_q + SEL_W'(1);
        end

        count_d = count_q + CNT_W'(accept_c) - CNT_W'(pop_last_c);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            sel_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            sel_q      <= sel_d;
            overflow_q <= overflow_d;
        end
    end

    // Beat storage: add lanes occupy serial slots 0..LANES-1, sub lanes the upper half.
    always_ff @(posedge clk) begin
        if (accept_c) begin
            for (int k = 0; k < int'(LANES); k++) begin
                mem_r_q[wr_ptr_q][k]         <= bus.din_add_r[k];
                mem_i_q[wr_ptr_q][k]         <= bus.din_add_i[k];
                mem_r_q[wr_ptr_q][LANES + k] <= bus.din_sub_r[k];
                mem_i_q[wr_ptr_q][LANES + k] <= bus.din_sub_i[k];
            end
        end
    end

    assign bus.dout_valid = dout_valid_c;
    assign bus.dout_r     = dout_valid_c ? mem_r_q[rd_ptr_q][sel_q] : '0;
    assign bus.dout_i     = dout_valid_c ? mem_i_q[rd_ptr_q][sel_q] : '0;
    assign bus.dout_idx   = sel_q;
    assign bus.dout_last  = (sel_q == SEL_W'(NSAMP - 1));
    assign bus.overflow   = overflow_q;
    assign bus.level      = count_q;
endmodule

// File: doc/fft_lane_serializer.md
Name: fft_lane_serializer

Overview:
- Receive-side unloader for the 16-lane parallel FFT stage outputs.
- Captures each valid beat of add/sub lanes (real and imaginary, 32 complex samples per beat) into a beat FIFO.
- Drains the FIFO as a serial complex stream with a valid/ready handshake, for downstream reorder or capture logic.
- The upstream stage has no backpressure, so input overflow is detected, flagged, and the offending beat is dropped.

Parameters:
- DATA_WIDTH, 13, bit width of each real/imag sample (signed two's complement).
- LANES, 16, lanes per add and per sub array.
- DEPTH, 4, FIFO depth in beats; must be a power of 2, minimum 2.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset; synchronous, active-high.
- din_valid  input  1  beat strobe: all four arrays are valid this cycle.
- din_add_r  input  [DATA_WIDTH-1:0] x LANES  add-path real, signed.
- din_add_i  input  [DATA_WIDTH-1:0] x LANES  add-path imag, signed.
- din_sub_r  input  [DATA_WIDTH-1:0] x LANES  sub-path real, signed.
- din_sub_i  input  [DATA_WIDTH-1:0] x LANES  sub-path imag, signed.
- dout_valid  output  1  serial sample available.
- dout_ready  input  1  downstream accepts the sample.
- dout_r  output  DATA_WIDTH  serial real, signed.
- dout_i  output  DATA_WIDTH  serial imag, signed.
- dout_idx  output  $clog2(2*LANES)  position of the sample within its beat.
- dout_last  output  1  high when dout_idx == 2*LANES-1.
- overflow  output  1  sticky dropped-beat flag.
- level  output  $clog2(DEPTH)+1  beats currently stored.

Behaviour:
- State:
  - Beat storage: DEPTH entries of 4*LANES words.
  - Pointers: wr_ptr and rd_ptr, each $clog2(DEPTH) bits, wrapping modulo DEPTH.
  - count: 0..DEPTH.
  - sel: 0..2*LANES-1.
- Reset (rst=1 at an edge): wr_ptr, rd_ptr, count, sel and overflow all go to 0. Storage contents are don't-care. Reset mid-stream discards all stored beats and any partial drain.
- Reset output values: dout_valid=0, dout_r=0, dout_i=0, dout_idx=0, dout_last=0, overflow=0, level=0.
- pop_last = dout_valid & dout_ready & (sel == 2*LANES-1).
- Write acceptance:
  - A beat is accepted when din_valid=1 and (count<DEPTH or pop_last).
  - An accepted beat is written to entry wr_ptr, then wr_ptr increments.
  - Otherwise, if din_valid=1, the beat is dropped and overflow is set; it stays set until rst.
- count update: count_next = count + accept - pop_last. level = count.
- Output side:
  - dout_valid = (count != 0).
  - dout_r/dout_i come from entry rd_ptr, selected by sel:
    - sel < LANES: add lane sel.
    - sel >= LANES: sub lane (sel-LANES).
  - dout_idx = sel.
  - dout_r/dout_i are 0 when count==0.
- Latency: a beat accepted at edge N gives dout_valid=1 with idx 0 in the cycle after edge N, provided the FIFO was empty.
- Handshake:
  - A transfer occurs on dout_valid & dout_ready.
  - On a transfer, sel increments. On pop_last, sel goes to 0 and rd_ptr increments.
  - While dout_valid=1 and dout_ready=0, dout_r, dout_i, dout_idx and dout_last hold stable.
  - dout_ready while dout_valid=0 has no effect.
- Simultaneous events:
  - Write and pop_last in the same cycle when full: the write is accepted, count is unchanged, no overflow.
  - Write while empty: no bypass; the first sample appears the next cycle.
- Arithmetic: none. Samples pass bit-exact, sign preserved.
- Throughput: one sample per cycle sustained. Back-to-back beats drain with no bubble between them (idx 31 is followed directly by idx 0 of the next beat).

Test Plan:
- Single beat, ready=1: add_r[k]=k, add_i[k]=-k, sub_r[k]=100+k, sub_i[k]=-100-k.
  - Expect 32 consecutive samples in cycles 1..32 after the beat.
  - Samples: (0,0),(1,-1)..(15,-15),(100,-100)..(115,-115).
  - idx 0..31, dout_last only at idx 31; dout_valid low from cycle 33, level returns to 0.
- Backpressure: same beat with dout_ready alternating 1,0.
  - Exactly 32 transfers, same order as above.
  - Outputs stable during ready=0 cycles; the drain takes 63 cycles.
- Overflow, DEPTH=4: 5 back-to-back beats with ready=0.
  - level=4, overflow=1, 5th beat dropped.
  - Then ready=1: 128 samples from beats 0-3 only. overflow stays 1.
- Full plus pop_last: level=4, ready=1, din_valid asserted on the cycle idx=31 transfers.
  - Beat accepted, level remains 4, overflow remains 0.
  - Drained data later includes the new beat.
- Reset mid-drain: assert rst at idx 10.
  - Next cycle: dout_valid=0, level=0, overflow=0, dout_r=dout_i=0.
  - A new beat then starts at idx 0.
- Extremes: lanes set to -4096 and 4095 alternating.
  - Serial outputs reproduce -4096 and 4095 exactly, sign intact.
